// File: rtl/regfile_wb_ctrl.sv
// ============================================================================
// Module   : regfile_wb_ctrl
// Purpose  : Write-back controller for the 32x32 general-register file.
//            Arbitrates the LSU and ALU write-back requesters onto the single
//            register-file write port. Keeps a pending-write scoreboard and
//            raises a read-after-write stall toward decode.
// Options  : `define WB_RR_EN selects round-robin arbitration on a tie.
//            Without it, LSU has fixed priority over ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // decode side
    input  logic                    i_issue_valid,
    input  logic [$clog2(NREG)-1:0] i_issue_rd,
    input  logic [$clog2(NREG)-1:0] i_rs1,
    input  logic [$clog2(NREG)-1:0] i_rs2,
    output logic                    o_stall,
    // LSU write-back
    input  logic                    i_lsu_valid,
    input  logic [$clog2(NREG)-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]         i_lsu_data,
    output logic                    o_lsu_ready,
    // ALU write-back
    input  logic                    i_alu_valid,
    input  logic [$clog2(NREG)-1:0] i_alu_rd,
    input  logic [XLEN-1:0]         i_alu_data,
    output logic                    o_alu_ready,
    // register-file write port
    output logic                    o_we,
    output logic [$clog2(NREG)-1:0] o_waddr,
    output logic [XLEN-1:0]         o_wdata,
    // scoreboard
    output logic [NREG-1:0]         o_busy
);

    localparam int c_ADDR_W = $clog2(NREG);

    logic                r_we;
    logic [c_ADDR_W-1:0] r_waddr;
    logic [XLEN-1:0]     r_wdata;
    logic [NREG-1:0]     r_busy;

    logic                w_prefer_lsu;
    logic                w_lsu_grant;
    logic                w_alu_grant;
    logic                w_grant;
    logic [c_ADDR_W-1:0] w_grant_rd;
    logic [XLEN-1:0]     w_grant_data;
    logic [NREG-1:0]     w_set;
    logic [NREG-1:0]     w_clr;
    logic [NREG-1:0]     w_busy_nxt;

`ifdef WB_RR_EN
    // 1 = LSU won the most recent tie; reset to ALU so LSU wins the first tie
    logic r_last_lsu;

    assign w_prefer_lsu = ~r_last_lsu;

    // Pointer advances only when both requesters compete
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_lsu <= 1'b0;
        end else if (i_lsu_valid && i_alu_valid) begin
            r_last_lsu <= w_lsu_grant;
        end
    end
`else
    assign w_prefer_lsu = 1'b1;
`endif

    // Grant: a lone requester wins immediately; a tie goes to the preferred side
    always_comb begin
        w_lsu_grant  = i_lsu_valid && (!i_alu_valid || w_prefer_lsu);
        w_alu_grant  = i_alu_valid && !w_lsu_grant;
        w_grant      = w_lsu_grant || w_alu_grant;
        w_grant_rd   = w_lsu_grant ? i_lsu_rd   : i_alu_rd;
        w_grant_data = w_lsu_grant ? i_lsu_data : i_alu_data;
    end

    assign o_lsu_ready = w_lsu_grant;
    assign o_alu_ready = w_alu_grant;

    // Register the granted request; x0 completes the handshake but never writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_grant && (w_grant_rd != '0);
            if (w_grant) begin
                r_waddr <= w_grant_rd;
                r_wdata <= w_grant_data;
            end
        end
    end

    // Scoreboard update: a same-cycle set overrides the clear (newer producer)
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (i_issue_valid && (i_issue_rd != '0)) begin
            w_set[i_issue_rd] = 1'b1;
        end
        if (r_we) begin
            w_clr[r_waddr] = 1'b1;
        end
        w_busy_nxt    = (r_busy & ~w_clr) | w_set;
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_we    = r_we;
    assign o_waddr = r_waddr;
    assign o_wdata = r_wdata;
    assign o_busy  = r_busy;

    // The file read is registered, so no forwarding: just hold decode
    assign o_stall = r_busy[i_rs1] | r_busy[i_rs2];

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
// ============================================================================
// Module   : tb_regfile_wb_ctrl
// Purpose  : Self-checking bench for regfile_wb_ctrl. Expected write-backs are
//            queued when a request is driven. A monitor pops and compares them
//            whenever the write port is enabled. A small register-file model
//            is written from the DUT write port and reset by rst_n.
// Options  : Honours `define WB_RR_EN for the collision expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_ctrl;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic             clk;
    logic             rst_n;
    logic             i_issue_valid;
    logic [4:0]       i_issue_rd;
    logic [4:0]       i_rs1;
    logic [4:0]       i_rs2;
    logic             o_stall;
    logic             i_lsu_valid;
    logic [4:0]       i_lsu_rd;
    logic [XLEN-1:0]  i_lsu_data;
    logic             o_lsu_ready;
    logic             i_alu_valid;
    logic [4:0]       i_alu_rd;
    logic [XLEN-1:0]  i_alu_data;
    logic             o_alu_ready;
    logic             o_we;
    logic [4:0]       o_waddr;
    logic [XLEN-1:0]  o_wdata;
    logic [NREG-1:0]  o_busy;

    int checks   = 0;
    int failures = 0;

    logic [36:0]     exp_q[$];
    logic [XLEN-1:0] rf[NREG];

    regfile_wb_ctrl #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue_valid (i_issue_valid),
        .i_issue_rd    (i_issue_rd),
        .i_rs1         (i_rs1),
        .i_rs2         (i_rs2),
        .o_stall       (o_stall),
        .i_lsu_valid   (i_lsu_valid),
        .i_lsu_rd      (i_lsu_rd),
        .i_lsu_data    (i_lsu_data),
        .o_lsu_ready   (o_lsu_ready),
        .i_alu_valid   (i_alu_valid),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .o_alu_ready   (o_alu_ready),
        .o_we          (o_we),
        .o_waddr       (o_waddr),
        .o_wdata       (o_wdata),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back({rd, data});
    endtask

    // Reference register file, written only from the DUT write port
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (o_we) begin
            rf[o_waddr] <= o_wdata;
        end
    end

    // Monitor: every enabled write must match the oldest queued expectation
    always @(negedge clk) begin
        logic [36:0] e;
        if (rst_n && o_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual=%0d/%h required=none", o_waddr, o_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", {27'd0, o_waddr}, {27'd0, e[36:32]});
                chk("wb_data", o_wdata, e[31:0]);
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        i_issue_valid = 1'b0;
        i_issue_rd    = '0;
        i_rs1         = 5'd5;
        i_rs2         = 5'd7;
        i_lsu_valid   = 1'b0;
        i_lsu_rd      = '0;
        i_lsu_data    = '0;
        i_alu_valid   = 1'b0;
        i_alu_rd      = '0;
        i_alu_data    = '0;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_we",        {31'd0, o_we},        32'd0);
        chk("rst_busy",      o_busy,               32'h0000_0000);
        chk("rst_stall",     {31'd0, o_stall},     32'd0);
        chk("rst_lsu_ready", {31'd0, o_lsu_ready}, 32'd0);
        chk("rst_alu_ready", {31'd0, o_alu_ready}, 32'd0);

        // ---------------- scoreboard and stall ----------------
        step();
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd5;
        step();
        i_issue_valid = 1'b0;
        #1;
        chk("sb_stall_set", {31'd0, o_stall}, 32'd1);
        chk("sb_busy_set",  o_busy,           32'h0000_0020);
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd5;
        i_alu_data  = 32'hDEAD_BEEF;
        push_wb(5'd5, 32'hDEAD_BEEF);
        #1;
        chk("sb_alu_ready", {31'd0, o_alu_ready}, 32'd1);
        chk("sb_lsu_idle",  {31'd0, o_lsu_ready}, 32'd0);
        step();
        i_alu_valid = 1'b0;
        #1;
        chk("sb_we",         {31'd0, o_we},     32'd1);
        chk("sb_waddr",      {27'd0, o_waddr},  32'd5);
        chk("sb_stall_hold", {31'd0, o_stall},  32'd1);
        step();
        chk("sb_stall_drop", {31'd0, o_stall},  32'd0);
        chk("sb_busy_clr",   o_busy,            32'h0000_0000);
        chk("sb_rf_x5",      rf[5],             32'hDEAD_BEEF);

        // ---------------- collision ----------------
        i_lsu_rd   = 5'd3;
        i_lsu_data = 32'h0000_0011;
        i_alu_rd   = 5'd4;
        i_alu_data = 32'h0000_0022;
`ifdef WB_RR_EN
        i_lsu_valid = 1'b1;
        i_alu_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_lsu_ready", {31'd0, o_lsu_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_alu_ready", {31'd0, o_alu_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 0) push_wb(5'd3, 32'h0000_0011);
            else            push_wb(5'd4, 32'h0000_0022);
            if (k > 0) chk("rr_waddr", {27'd0, o_waddr}, (k % 2 == 1) ? 32'd3 : 32'd4);
            step();
        end
        i_lsu_valid = 1'b0;
        i_alu_valid = 1'b0;
        #1;
        chk("rr_waddr_last", {27'd0, o_waddr}, 32'd4);
`else
        i_lsu_valid = 1'b1;
        i_alu_valid = 1'b1;
        #1;
        chk("col_lsu_first", {31'd0, o_lsu_ready}, 32'd1);
        chk("col_alu_wait",  {31'd0, o_alu_ready}, 32'd0);
        push_wb(5'd3, 32'h0000_0011);
        step();
        i_lsu_valid = 1'b0;
        #1;
        chk("col_alu_second", {31'd0, o_alu_ready}, 32'd1);
        chk("col_waddr_1",    {27'd0, o_waddr},     32'd3);
        push_wb(5'd4, 32'h0000_0022);
        step();
        i_alu_valid = 1'b0;
        #1;
        chk("col_waddr_2", {27'd0, o_waddr}, 32'd4);
`endif
        step();

        // ---------------- x0 ----------------
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd0;
        step();
        i_issue_valid = 1'b0;
        #1;
        chk("x0_busy_issue", o_busy, 32'h0000_0000);
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd0;
        i_alu_data  = 32'hFFFF_FFFF;
        #1;
        chk("x0_alu_ready", {31'd0, o_alu_ready}, 32'd1);
        step();
        i_alu_valid = 1'b0;
        #1;
        chk("x0_we",   {31'd0, o_we}, 32'd0);
        chk("x0_busy", o_busy,        32'h0000_0000);
        step();
        chk("x0_rf", rf[0], 32'h0000_0000);

        // ---------------- set/clear race ----------------
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd9;
        step();
        i_issue_valid = 1'b0;
        #1;
        chk("race_busy_pre", o_busy, 32'h0000_0200);
        i_lsu_valid = 1'b1;
        i_lsu_rd    = 5'd9;
        i_lsu_data  = 32'h0000_0099;
        push_wb(5'd9, 32'h0000_0099);
        step();
        i_lsu_valid   = 1'b0;
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd9;
        #1;
        chk("race_we",    {31'd0, o_we},    32'd1);
        chk("race_waddr", {27'd0, o_waddr}, 32'd9);
        step();
        i_issue_valid = 1'b0;
        #1;
        chk("race_busy_kept", o_busy, 32'h0000_0200);

        // ---------------- mid-flight reset ----------------
        i_issue_valid = 1'b1;
        i_issue_rd    = 5'd12;
        step();
        i_issue_valid = 1'b0;
        i_lsu_valid   = 1'b1;
        i_lsu_rd      = 5'd12;
        i_lsu_data    = 32'h0000_C0C0;
        #1;
        chk("mf_lsu_ready", {31'd0, o_lsu_ready}, 32'd1);
        step();
        i_lsu_valid = 1'b0;
        chk("mf_we_pre", {31'd0, o_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mf_we_rst",   {31'd0, o_we}, 32'd0);
        chk("mf_busy_rst", o_busy,        32'h0000_0000);
        step();
        step();
        rst_n = 1'b1;
        i_rs1 = 5'd12;
        #1;
        chk("mf_stall", {31'd0, o_stall}, 32'd0);
        chk("mf_rf12",  rf[12],           32'h0000_0000);
        step();

        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
